// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, A-source selects, FSM state and result helpers
// The combinational datapath lives here so both shifter builds produce identical results.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1100;

    localparam logic [1:0] ASEL_A     = 2'b00;
    localparam logic [1:0] ASEL_SHAMT = 2'b01;
    localparam logic [1:0] ASEL_LUI   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SH_LL = 2'b00,
        SH_RL = 2'b01,
        SH_RA = 2'b10
    } shift_mode_e;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        illegal;
    } alu_res_t;

    function automatic logic is_shift(input logic [3:0] ctr);
        return (ctr == ALU_SLL) || (ctr == ALU_SRL) || (ctr == ALU_SRA);
    endfunction

    function automatic shift_mode_e shift_mode(input logic [3:0] ctr);
        case (ctr)
            ALU_SRL: return SH_RL;
            ALU_SRA: return SH_RA;
            default: return SH_LL;
        endcase
    endfunction

    function automatic alu_res_t alu_compute(input logic [3:0]  ctr,
                                             input logic [31:0] op_a,
                                             input logic [31:0] op_b);
        alu_res_t r;
        r = '0;
        case (ctr)
            ALU_ADD: begin
                r.result = op_a + op_b;
                r.ovf    = (op_a[31] == op_b[31]) && (r.result[31] != op_a[31]);
            end
            ALU_ADDU: r.result = op_a + op_b;
            ALU_SUB: begin
                r.result = op_a - op_b;
                r.ovf    = (op_a[31] != op_b[31]) && (r.result[31] != op_a[31]);
            end
            ALU_AND: r.result = op_a & op_b;
            ALU_OR:  r.result = op_a | op_b;
            ALU_XOR: r.result = op_a ^ op_b;
            ALU_SLL: r.result = op_b << op_a[4:0];
            ALU_SRL: r.result = op_b >> op_a[4:0];
            ALU_SRA: r.result = $unsigned($signed(op_b) >>> op_a[4:0]);
            ALU_SLT: r.result = {31'd0, ($signed(op_a) < $signed(op_b))};
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/response bundle between a requester and alu_exec
// master drives the request side, slave (the ALU) drives ready/done and results.
interface alu_exec_if;
    logic        start;
    logic [3:0]  alu_ctr;
    logic [1:0]  asel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;

    modport master (
        output start, alu_ctr, asel, a, b, shamt,
        input  ready, done, result, zero, ovf, illegal
    );

    modport slave (
        input  start, alu_ctr, asel, a, b, shamt,
        output ready, done, result, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - iterative one-bit-per-cycle shifter
// finished_o flags that the current step is the last one, so step_data_o is the final value.
module alu_shifter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  shift_mode_e mode_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  amount_i,
    output logic [31:0] step_data_o,
    output logic        finished_o
);
    logic [31:0] data_q;
    logic [4:0]  count_q;
    shift_mode_e mode_q;

    always_comb begin
        step_data_o = {data_q[30:0], 1'b0};
        case (mode_q)
            SH_RL:   step_data_o = {1'b0, data_q[31:1]};
            SH_RA:   step_data_o = {data_q[31], data_q[31:1]};
            default: step_data_o = {data_q[30:0], 1'b0};
        endcase
    end

    assign finished_o = (count_q == 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            mode_q  <= SH_LL;
        end else if (load_i) begin
            data_q  <= data_i;
            count_q <= amount_i;
            mode_q  <= mode_i;
        end else if (step_i && (count_q != 5'd0)) begin
            data_q  <= step_data_o;
            count_q <= count_q - 5'd1;
        end
    end
endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - start/done ALU with iterative shifts; ALU_EXEC_FAST_SHIFT_EN selects a barrel shifter
// Outputs are registered and held from done until the next accepted start.
module alu_exec
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_exec_if.slave   bus
);
    state_e      state_q;
    logic        ready_q;
    logic        done_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        ovf_q;
    logic        illegal_q;

    logic [31:0] op_a;
    alu_res_t    calc;
    logic        accept;
    logic        need_iter;
    logic [31:0] sh_data;
    logic        sh_finished;

    always_comb begin
        op_a = bus.a;
        case (bus.asel)
            ASEL_SHAMT: op_a = {27'd0, bus.shamt};
            ASEL_LUI:   op_a = 32'd16;
            default:    op_a = bus.a;
        endcase
    end

    assign calc   = alu_compute(bus.alu_ctr, op_a, bus.b);
    assign accept = bus.start && ready_q;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    assign need_iter   = 1'b0;
    assign sh_data     = '0;
    assign sh_finished = 1'b1;
`else
    // A zero shift amount is just b, so it takes the single-cycle path.
    assign need_iter = is_shift(bus.alu_ctr) && (op_a[4:0] != 5'd0);

    alu_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept && need_iter),
        .step_i      (state_q == ST_SHIFT),
        .mode_i      (shift_mode(bus.alu_ctr)),
        .data_i      (bus.b),
        .amount_i    (op_a[4:0]),
        .step_data_o (sh_data),
        .finished_o  (sh_finished)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (need_iter) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            result_q  <= calc.result;
                            zero_q    <= (calc.result == 32'd0);
                            ovf_q     <= calc.ovf;
                            illegal_q <= calc.illegal;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sh_finished) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        result_q  <= sh_data;
                        zero_q    <= (sh_data == 32'd0);
                        ovf_q     <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.ovf     = ovf_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed vector bench for alu_exec
// Honours ALU_EXEC_FAST_SHIFT_EN for expected latencies.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_exec_if bus();

    alu_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  ctr;
        logic [1:0]  asel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        int          iter_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [3:0] c, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                input logic [31:0] r, input logic o, input logic il, input int lat);
        vec_t v;
        v.name = n; v.ctr = c; v.asel = s; v.a = a; v.b = b; v.shamt = sh;
        v.res = r; v.ovf = o; v.ill = il; v.iter_lat = lat;
        return v;
    endfunction

    function automatic int exp_lat(input int iter_lat);
`ifdef ALU_EXEC_FAST_SHIFT_EN
        return (iter_lat > 0) ? 1 : 1;
`else
        return iter_lat;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        bus.alu_ctr = c; bus.asel = s; bus.a = a; bus.b = b; bus.shamt = sh;
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        lat = 0;
        @(negedge clk);
        check({v.name, ".ready_idle"}, {31'd0, bus.ready}, 32'd1);
        drive(v.ctr, v.asel, v.a, v.b, v.shamt);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drive(~v.ctr, ~v.asel, ~v.a, ~v.b, ~v.shamt);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) check({v.name, ".ready_busy"}, {31'd0, bus.ready}, 32'd0);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        check({v.name, ".latency"}, lat, exp_lat(v.iter_lat));
        check({v.name, ".result"}, bus.result, v.res);
        check({v.name, ".zero"}, {31'd0, bus.zero}, {31'd0, (v.res == 32'd0)});
        check({v.name, ".ovf"}, {31'd0, bus.ovf}, {31'd0, v.ovf});
        check({v.name, ".illegal"}, {31'd0, bus.illegal}, {31'd0, v.ill});
        @(negedge clk);
        check({v.name, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({v.name, ".ready_after"}, {31'd0, bus.ready}, 32'd1);
        check({v.name, ".result_held"}, bus.result, v.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int dcyc;
        logic [31:0] dres;

        vecs.push_back(mk("add_ovf",   ALU_ADD,  ASEL_A,     32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("addu",      ALU_ADDU, ASEL_A,     32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sra4",      ALU_SRA,  ASEL_SHAMT, 32'h00000000, 32'hF0000000, 5'd4,  32'hFF000000, 1'b0, 1'b0, 5));
        vecs.push_back(mk("lui",       ALU_SLL,  ASEL_LUI,   32'h00000000, 32'h00001234, 5'd0,  32'h12340000, 1'b0, 1'b0, 17));
        vecs.push_back(mk("slt_neg",   ALU_SLT,  ASEL_A,     32'hFFFFFFFF, 32'h00000000, 5'd0,  32'h00000001, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sub_zero",  ALU_SUB,  ASEL_A,     32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("ill_0011",  4'b0011,  ASEL_A,     32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("and",       ALU_AND,  ASEL_A,     32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("or",        ALU_OR,   ASEL_A,     32'h0F0F0000, 32'h000000FF, 5'd0,  32'h0F0F00FF, 1'b0, 1'b0, 1));
        vecs.push_back(mk("xor",       ALU_XOR,  ASEL_A,     32'hAAAAAAAA, 32'hFFFFFFFF, 5'd0,  32'h55555555, 1'b0, 1'b0, 1));
        vecs.push_back(mk("srl3",      ALU_SRL,  ASEL_A,     32'h00000003, 32'h80000001, 5'd0,  32'h10000000, 1'b0, 1'b0, 4));
        vecs.push_back(mk("sll0",      ALU_SLL,  ASEL_SHAMT, 32'hFFFFFFFF, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sub_ovf",   ALU_SUB,  ASEL_A,     32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 1));
        vecs.push_back(mk("slt_pos",   ALU_SLT,  ASEL_A,     32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sra31_pos", ALU_SRA,  ASEL_SHAMT, 32'h00000000, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0, 1'b0, 32));
        vecs.push_back(mk("add_shamt", ALU_ADD,  ASEL_SHAMT, 32'hFFFFFFFF, 32'h0000000A, 5'd5,  32'h0000000F, 1'b0, 1'b0, 1));
        vecs.push_back(mk("ill_1111",  4'b1111,  ASEL_A,     32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("sll_a_lo5", ALU_SLL,  ASEL_A,     32'h00000021, 32'h00000001, 5'd0,  32'h00000002, 1'b0, 1'b0, 2));

        rst = 1'b1;
        bus.start = 1'b0;
        drive(4'd0, 2'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("rst.ready",   {31'd0, bus.ready},   32'd1);
        check("rst.done",    {31'd0, bus.done},    32'd0);
        check("rst.result",  bus.result,           32'd0);
        check("rst.zero",    {31'd0, bus.zero},    32'd0);
        check("rst.ovf",     {31'd0, bus.ovf},     32'd0);
        check("rst.illegal", {31'd0, bus.illegal}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // start pulses while busy must be dropped, giving exactly one done
        @(negedge clk);
        drive(ALU_SLL, ASEL_SHAMT, 32'd0, 32'h00000001, 5'd31);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0; dcyc = 0; dres = '0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                ndone++; dcyc = c; dres = bus.result;
            end
            if ((c == 1 || c == 10 || c == 20) && c <= exp_lat(32)) begin
                drive(ALU_ADD, ASEL_A, 32'd1, 32'd1, 5'd0);
                bus.start = 1'b1;
            end
        end
        check("busy_start.done_count", ndone, 1);
        check("busy_start.done_cycle", dcyc, exp_lat(32));
        check("busy_start.result", dres, 32'h80000000);

        // asynchronous reset in cycle 10 of a 31-bit shift
        @(negedge clk);
        drive(ALU_SRL, ASEL_SHAMT, 32'd0, 32'hFFFFFFFF, 5'd31);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort.done_before_rst", ndone, (exp_lat(32) <= 10) ? 1 : 0);
        #2 rst = 1'b1;
        #1;
        check("abort.ready",   {31'd0, bus.ready},   32'd1);
        check("abort.done",    {31'd0, bus.done},    32'd0);
        check("abort.result",  bus.result,           32'd0);
        check("abort.zero",    {31'd0, bus.zero},    32'd0);
        check("abort.ovf",     {31'd0, bus.ovf},     32'd0);
        check("abort.illegal", {31'd0, bus.illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort.no_done_after", ndone, 0);
        check("abort.result_zero", bus.result, 32'd0);

        run_op(vecs[12]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  in  1  request; accepted only when ready=1.
REQ-004 SHALL provide: alu_ctr  in  4  operation code, same encoding as the ALU control decoder output.
REQ-005 SHALL provide: asel  in  2  A-source select: 00 A=a, 01 A=shamt, 10 A=16 (lui).
REQ-006 SHALL provide: a  in  32; b  in  32; shamt  in  5  operands.
REQ-007 SHALL provide: ready  out  1  high in IDLE only.
REQ-008 SHALL provide: done  out  1  one-cycle pulse, result valid.
REQ-009 SHALL provide: result  out  32; zero  out  1 (result==0); ovf  out  1; illegal  out  1.

Function
REQ-010 SHALL decode: 0000 add, 0001 addu, 0010 sub, 0100 and, 0101 or, 0110 xor, 1000 sll, 1001 srl, 1010 slt (signed, result 0/1), 1100 sra; all other codes illegal.
REQ-011 SHALL compute shifts as b shifted by A[4:0]; asel=10 with 1000 yields b<<16.
REQ-012 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; non-shift ops and shift amount 0 go IDLE -> DONE.
REQ-013 SHALL sample all inputs in the cycle start&&ready is high; later input changes SHALL NOT affect the operation.
REQ-014 SHALL assert done in cycle 1 after acceptance for non-shift ops, and in cycle n+1 for a shift by n (iterative, 1 bit per cycle).
REQ-015 SHALL hold result/zero/ovf/illegal stable from done until the next accepted start.
REQ-016 SHALL set ovf only for add/sub on signed overflow; addu never sets ovf.
REQ-017 SHALL, for illegal codes, return result=0, zero=1, illegal=1, latency 1.
REQ-018 SHALL ignore start while ready=0 (no queuing); ready returns high the cycle after done.
REQ-019 SHALL use sra sign-fill from b[31]; srl zero-fill.

Reset
REQ-020 SHALL on rst force IDLE, ready=1, done=0, result=0, zero=0, ovf=0, illegal=0, immediately and asynchronously.
REQ-021 SHALL abort an in-flight shift on rst with no done pulse.

Configuration
REQ-022 SHALL, with ALU_EXEC_FAST_SHIFT_EN defined, use a barrel shifter: every op latency 1, SHIFT state unused.
REQ-023 SHALL, without ALU_EXEC_FAST_SHIFT_EN, use the iterative shifter of REQ-014; results identical in both builds.

Structure
REQ-024 SHALL place the 4-bit alu_ctr code constants, asel codes and FSM state type in shared package alu_pkg.
REQ-025 SHALL implement the iterative shifter as sub-module alu_shifter (load, step, count, finished).

Verification
REQ-026 add a=0x7FFFFFFF b=1 -> done at cycle 1, result 0x80000000, ovf=1; addu same -> ovf=0.
REQ-027 sra asel=01 shamt=4 b=0xF0000000 -> done at cycle 5, result 0xFF000000; fast build cycle 1.
REQ-028 lui alu_ctr=1000 asel=10 b=0x00001234 -> result 0x12340000.
REQ-029 slt a=0xFFFFFFFF b=0 -> result 1; sub a=5 b=5 -> result 0, zero=1.
REQ-030 start pulsed during shift by 31 -> ignored, single done; rst at cycle 10 -> IDLE, no done, outputs 0.
REQ-031 alu_ctr=0011 -> illegal=1, result 0, done at cycle 1.
